// File: rtl/nand_dq_burst_model.sv
`default_nettype none
// ============================================================================
//  Module   : nand_dq_burst_model
//  Purpose  : NAND-side read-burst responder. For a read on exactly one chip
//             enable it drives a DQS preamble, BURST_LEN DQS-framed data
//             beats and a postamble. Data comes from a fixed pattern, a
//             per-chip counter or, with NAND_MODEL_LFSR_EN defined, a 16-bit
//             LFSR. Only value/output-enable pairs are exported.
//  Options  : `define NAND_MODEL_LFSR_EN builds the LFSR source for mode 2;
//             otherwise mode 2 behaves as mode 0.
//  Revision : 1.0 - initial release
// ============================================================================
module nand_dq_burst_model #(
   parameter int          DQ_W      = 8,
   parameter int          NUM_CE    = 4,
   parameter int          BURST_LEN = 4,
   parameter logic [31:0] PATTERN   = 32'hDEADBEEF
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic [NUM_CE-1:0] cen,
   input  logic              cle,
   input  logic              ale,
   input  logic              wrn,
   input  logic [1:0]        mode,
   output logic [DQ_W-1:0]   dq_out,
   output logic              dq_oe,
   output logic              dqs_out,
   output logic              dqs_oe,
   output logic              busy,
   output logic              burst_done,
   output logic              err_multi_ce
);

   localparam int c_SEL_W  = (NUM_CE > 1) ? $clog2(NUM_CE) : 1;
   localparam int c_CNT_W  = $clog2(NUM_CE + 1);
   localparam int c_BEAT_W = (BURST_LEN > 4) ? $clog2(BURST_LEN) : 2;
   localparam int c_PAT_W  = 4 * DQ_W;
   localparam logic [c_PAT_W-1:0]  c_PAT  = c_PAT_W'(PATTERN);
   localparam logic [c_BEAT_W-1:0] c_LAST = c_BEAT_W'(BURST_LEN - 1);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_PREAMBLE  = 2'd1,
      S_DATA      = 2'd2,
      S_POSTAMBLE = 2'd3
   } state_t;

   state_t                r_state, w_state_nx;
   logic [c_SEL_W-1:0]    r_sel, w_sel;
   logic [c_CNT_W-1:0]    w_low_cnt;
   logic [1:0]            r_mode;
   logic [c_BEAT_W-1:0]   r_beat;
   logic [DQ_W-1:0]       r_cnt [NUM_CE];
   logic [DQ_W-1:0]       w_pat_slice [4];
   logic [DQ_W-1:0]       w_beat_data;
   logic                  w_rd, w_req, w_multi, w_keep, w_beat_adv;
   logic [DQ_W-1:0]       r_dq, w_dq_nx;
   logic                  r_dq_oe, r_dqs, r_dqs_oe, r_busy, r_done, r_err;
   logic                  w_dq_oe_nx, w_dqs_nx, w_dqs_oe_nx, w_busy_nx, w_done_nx;
`ifdef NAND_MODEL_LFSR_EN
   logic [15:0]           r_lfsr;
`endif

   // Fixed-pattern slices, most significant slice first (beat index mod 4).
   for (genvar k = 0; k < 4; k++) begin : g_pat
      assign w_pat_slice[k] = c_PAT[(4-k)*DQ_W-1 -: DQ_W];
   end

   // Decode a read request: direction read, no latch strobes, count CEs low.
   always_comb begin
      w_low_cnt = '0;
      w_sel     = '0;
      for (int i = 0; i < NUM_CE; i++) begin
         if (!cen[i]) begin
            w_low_cnt = w_low_cnt + c_CNT_W'(1);
            w_sel     = c_SEL_W'(i);
         end
      end
      w_rd    = !ale && !cle && !wrn;
      w_req   = w_rd && (w_low_cnt == c_CNT_W'(1));
      w_multi = w_rd && (w_low_cnt > c_CNT_W'(1));
      w_keep  = w_req && (w_sel == r_sel);
   end

   // Beat data source, selected by the mode latched at burst start.
   always_comb begin
      w_beat_data = w_pat_slice[r_beat[1:0]];
      case (r_mode)
         2'd1:    w_beat_data = r_cnt[r_sel];
`ifdef NAND_MODEL_LFSR_EN
         2'd2:    w_beat_data = r_lfsr[DQ_W-1:0];
`endif
         default: w_beat_data = w_pat_slice[r_beat[1:0]];
      endcase
   end

   // Next state and next registered bus outputs; an abort yields idle outputs.
   always_comb begin
      w_state_nx  = r_state;
      w_dq_nx     = '0;
      w_dq_oe_nx  = 1'b0;
      w_dqs_nx    = 1'b0;
      w_dqs_oe_nx = 1'b0;
      w_busy_nx   = 1'b0;
      w_done_nx   = 1'b0;
      w_beat_adv  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_req) w_state_nx = S_PREAMBLE;
         end
         S_PREAMBLE: begin
            if (w_keep) begin
               w_state_nx  = S_DATA;
               w_dqs_oe_nx = 1'b1;
               w_busy_nx   = 1'b1;
            end else begin
               w_state_nx  = S_IDLE;
            end
         end
         S_DATA: begin
            if (w_keep) begin
               w_dq_nx     = w_beat_data;
               w_dq_oe_nx  = 1'b1;
               w_dqs_nx    = ~r_beat[0];
               w_dqs_oe_nx = 1'b1;
               w_busy_nx   = 1'b1;
               w_beat_adv  = 1'b1;
               if (r_beat == c_LAST) w_state_nx = S_POSTAMBLE;
            end else begin
               w_state_nx  = S_IDLE;
            end
         end
         S_POSTAMBLE: begin
            w_state_nx  = S_IDLE;
            w_dqs_oe_nx = 1'b1;
            w_busy_nx   = 1'b1;
            w_done_nx   = 1'b1;
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge CLK) begin
      if (!RST_N) r_state <= S_IDLE;
      else        r_state <= w_state_nx;
   end

   // Registered outputs, burst context, per-chip counters and LFSR.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_dq     <= '0;
         r_dq_oe  <= 1'b0;
         r_dqs    <= 1'b0;
         r_dqs_oe <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
         r_sel    <= '0;
         r_mode   <= 2'd0;
         r_beat   <= '0;
         for (int i = 0; i < NUM_CE; i++) r_cnt[i] <= '0;
`ifdef NAND_MODEL_LFSR_EN
         r_lfsr   <= 16'hACE1;
`endif
      end else begin
         r_dq     <= w_dq_nx;
         r_dq_oe  <= w_dq_oe_nx;
         r_dqs    <= w_dqs_nx;
         r_dqs_oe <= w_dqs_oe_nx;
         r_busy   <= w_busy_nx;
         r_done   <= w_done_nx;
         if (w_multi) r_err <= 1'b1;
         if (r_state == S_IDLE && w_req) begin
            r_sel  <= w_sel;
            r_mode <= mode;
            r_beat <= '0;
         end else if (w_beat_adv) begin
            r_beat <= r_beat + c_BEAT_W'(1);
         end
         if (w_beat_adv && r_mode == 2'd1) r_cnt[r_sel] <= r_cnt[r_sel] + DQ_W'(1);
`ifdef NAND_MODEL_LFSR_EN
         // x^16+x^14+x^13+x^11+1, right-shifting Fibonacci form.
         if (w_beat_adv && r_mode == 2'd2)
            r_lfsr <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
`endif
      end
   end

   assign dq_out       = r_dq;
   assign dq_oe        = r_dq_oe;
   assign dqs_out      = r_dqs;
   assign dqs_oe       = r_dqs_oe;
   assign busy         = r_busy;
   assign burst_done   = r_done;
   assign err_multi_ce = r_err;

endmodule
`default_nettype wire

// File: tb/tb_nand_dq_burst_model.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nand_dq_burst_model
//  Purpose  : Self-checking bench for nand_dq_burst_model (default params).
//             Expected beats are queued when a burst is driven and popped
//             whenever the DUT drives DQ. Honours NAND_MODEL_LFSR_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_nand_dq_burst_model;

   localparam int          DQ_W   = 8;
   localparam int          NCE    = 4;
   localparam int          BL     = 4;
   localparam logic [31:0] TB_PAT = 32'hDEADBEEF;

   logic            CLK = 1'b0;
   logic            RST_N;
   logic [NCE-1:0]  cen;
   logic            cle, ale, wrn;
   logic [1:0]      mode;
   logic [DQ_W-1:0] dq_out;
   logic            dq_oe, dqs_out, dqs_oe, busy, burst_done, err_multi_ce;

   int n_cmp = 0;
   int n_err = 0;

   logic [8:0]      exp_q [$];
   logic [DQ_W-1:0] m_cnt [NCE];
   logic [15:0]     m_lfsr;

   nand_dq_burst_model #(
      .DQ_W(DQ_W), .NUM_CE(NCE), .BURST_LEN(BL), .PATTERN(TB_PAT)
   ) dut (
      .CLK(CLK), .RST_N(RST_N), .cen(cen), .cle(cle), .ale(ale), .wrn(wrn),
      .mode(mode), .dq_out(dq_out), .dq_oe(dq_oe), .dqs_out(dqs_out),
      .dqs_oe(dqs_oe), .busy(busy), .burst_done(burst_done),
      .err_multi_ce(err_multi_ce)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic reset_model();
      for (int i = 0; i < NCE; i++) m_cnt[i] = '0;
      m_lfsr = 16'hACE1;
   endtask

   // Reference value of one beat; advances the counter / LFSR models.
   function automatic logic [DQ_W-1:0] model_beat(input int ce, input logic [1:0] md, input int b);
      logic [31:0]     pat;
      logic [DQ_W-1:0] r;
      pat = TB_PAT;
      r   = pat[(3 - (b % 4)) * 8 +: 8];
      if (md == 2'd1) begin
         r         = m_cnt[ce];
         m_cnt[ce] = m_cnt[ce] + 8'd1;
      end
`ifdef NAND_MODEL_LFSR_EN
      if (md == 2'd2) begin
         r      = m_lfsr[7:0];
         m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
      end
`endif
      return r;
   endfunction

   // Scoreboard: every driven DQ beat must match the head of the queue.
   always @(negedge CLK) begin
      if (dq_oe === 1'b1) begin
         if (exp_q.size() == 0) chk("sb_underflow", 32'(exp_q.size()), 32'd1);
         else chk("beat", 32'({dqs_out, dq_out}), 32'(exp_q.pop_front()));
      end
   end

   // One read burst on CE ce; abort_after >= 1 raises ale after that many beats.
   task automatic do_burst(input int ce, input logic [1:0] md, input int abort_after);
      int   busy_n = 0;
      int   done_n = 0;
      int   beats;
      logic ph;
      beats = (abort_after < 0) ? BL : abort_after;
      for (int b = 0; b < beats; b++) begin
         ph = ~b[0];
         exp_q.push_back({ph, model_beat(ce, md, b)});
      end
      @(negedge CLK);
      cen = ~(NCE'(1) << ce); ale = 1'b0; cle = 1'b0; wrn = 1'b0; mode = md;
      for (int c = 0; c < BL + 4; c++) begin
         @(negedge CLK);
         if (busy === 1'b1) busy_n++;
         if (burst_done === 1'b1) done_n++;
         if (c == 0) chk("start_latency_busy", 32'(busy), 32'd0);
         if (c == 1) begin
            chk("preamble", 32'({dqs_oe, dqs_out, dq_oe, busy}), 32'b1001);
            mode = ~md;   // must be ignored until the next burst
         end
         if (abort_after < 0 && c == BL + 2) begin
            chk("postamble", 32'({dqs_oe, dqs_out, dq_oe, burst_done}), 32'b1001);
            cen = '1; wrn = 1'b1;
         end
         if (abort_after >= 0 && c == abort_after + 1) ale = 1'b1;
         if (abort_after >= 0 && c == abort_after + 2)
            chk("abort_idle", 32'({dq_oe, dqs_oe, busy}), 32'b000);
      end
      cen = '1; wrn = 1'b1; ale = 1'b0;
      chk("busy_cycles", 32'(busy_n), (abort_after < 0) ? 32'(BL + 2) : 32'(abort_after + 1));
      chk("done_pulses", 32'(done_n), (abort_after < 0) ? 32'd1 : 32'd0);
   endtask

   initial begin
      RST_N = 1'b0; cen = '1; cle = 1'b0; ale = 1'b0; wrn = 1'b1; mode = 2'd0;
      reset_model();
      repeat (3) @(negedge CLK);
      chk("reset_outputs", 32'({dq_out, dq_oe, dqs_out, dqs_oe, busy, burst_done, err_multi_ce}), 32'd0);
      RST_N = 1'b1;
      repeat (2) @(negedge CLK);

      // Fixed pattern, and reserved mode 3 behaving as mode 0.
      do_burst(0, 2'd0, -1);
      do_burst(2, 2'd3, -1);

      // Counter persistence and wrap on CE0, isolation on CE1.
      for (int i = 0; i < 64; i++) do_burst(0, 2'd1, -1);
      do_burst(1, 2'd1, -1);
      do_burst(0, 2'd1, -1);

      // Abort after two beats: CE2 counter must advance by exactly two.
      do_burst(2, 2'd1, 2);
      do_burst(2, 2'd1, -1);

      // LFSR source (pattern when the LFSR is not built); state persists.
      do_burst(3, 2'd2, -1);
      do_burst(3, 2'd2, -1);

      // Multi-CE request: nothing driven, sticky error until reset.
      @(negedge CLK);
      cen = 4'b1100; wrn = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge CLK);
         chk("multi_no_drive", 32'({dq_oe, dqs_oe, busy}), 32'd0);
      end
      cen = '1; wrn = 1'b1;
      repeat (3) @(negedge CLK);
      chk("multi_err_sticky", 32'(err_multi_ce), 32'd1);
      RST_N = 1'b0;
      @(negedge CLK);
      chk("multi_err_cleared", 32'(err_multi_ce), 32'd0);
      RST_N = 1'b1;
      reset_model();
      @(negedge CLK);

      // Reset while beat 2 is on the bus, then a fresh counter burst.
      do_burst(1, 2'd1, -1);   // advance CE1 so the reset is observable
      begin
         logic ph;
         for (int b = 0; b < 3; b++) begin
            ph = ~b[0];
            exp_q.push_back({ph, model_beat(0, 2'd1, b)});
         end
      end
      @(negedge CLK);
      cen = 4'b1110; ale = 1'b0; cle = 1'b0; wrn = 1'b0; mode = 2'd1;
      repeat (5) @(negedge CLK);
      RST_N = 1'b0;
      @(negedge CLK);
      chk("reset_mid_burst", 32'({dq_out, dq_oe, dqs_out, dqs_oe, busy, burst_done, err_multi_ce}), 32'd0);
      RST_N = 1'b1; cen = '1; wrn = 1'b1;
      reset_model();
      @(negedge CLK);
      do_burst(0, 2'd1, -1);
      do_burst(1, 2'd1, -1);

      repeat (2) @(negedge CLK);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
